cla_arb: RTL and testbench
==========================

CLA_ARB -- requirements
Module: cla_arb

Interface
REQ-001 Parameters: none; width is fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester 0/1 operation is accepted this cycle; combinational.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  requester operands.
REQ-007 req0_ci / req1_ci  input  1  requester carry-in.
REQ-008 req0_sub / req1_sub  input  1  requester subtract select; present only with CLA_ARB_SUB_EN.
REQ-009 rsp_valid  output  1  response register holds a result.
REQ-010 rsp_ready  input  1  consumer accepts the response this cycle.
REQ-011 rsp_id  output  1  requester index that owns the response.
REQ-012 rsp_s  output  32  sum; rsp_co  output  1  carry-out.

Function
REQ-013 The block SHALL share one internal cla32 adder between two requesters through a 2-stage pipeline: S1 (operand register: a, b, ci, id, v1) and S2 (response register: s, co, id, rsp_valid).
REQ-014 A transfer on port n SHALL occur when reqn_valid and reqn_ready are both 1 at a rising edge.
REQ-015 Define adv2 = !rsp_valid | rsp_ready and adv1 = !v1 | adv2.
REQ-016 At most one reqn_ready SHALL be 1 in any cycle; reqn_ready = adv1 & grant==n & reqn_valid.
REQ-017 Grant SHALL be round-robin: if only one requester is valid, it is granted; if both are valid, the requester not in last_grant is granted.
REQ-018 last_grant SHALL update to n only on an accepted transfer from port n.
REQ-019 On a transfer, S1 SHALL load the operands, the ci and the id, and set v1=1; when adv1 holds with no transfer, v1 SHALL clear.
REQ-020 When adv2 holds, S2 SHALL load the adder outputs of S1 and set rsp_valid=v1.
REQ-021 When adv2 is 0, S2 and S1 SHALL hold their contents, and no transfer SHALL occur if v1=1.
REQ-022 Latency: a transfer at edge t SHALL produce rsp_valid=1 after edge t+1 if the response path is not stalled.
REQ-023 Throughput SHALL be one operation per cycle while rsp_ready=1.
REQ-024 Consumption and refill in the same cycle: if rsp_valid&rsp_ready and v1=1 at an edge, S2 SHALL take the new result with no bubble.
REQ-025 Responses SHALL leave in acceptance order, and rsp_id SHALL match the accepting port.
REQ-026 rsp_s and rsp_co SHALL equal the 33-bit a+b+ci truncated to 32 bits, plus the carry-out.
REQ-027 Wrap-around: 0xFFFFFFFF+0x00000001+0 SHALL give rsp_s=0 and rsp_co=1.
REQ-028 A requester SHALL keep reqn_valid and its operands stable until accepted; the block does not check this.

Reset
REQ-029 While reset_n=0, the block SHALL force v1=0, rsp_valid=0, rsp_id=0, rsp_s=0, rsp_co=0 and last_grant=1, so that requester 0 wins the first contention.
REQ-030 Reset asserted mid-operation SHALL discard the S1 and S2 contents without producing a response.
REQ-031 With reset_n=0, req0_ready and req1_ready SHALL read 1 only through REQ-016 with v1=0; no transfer SHALL be recorded until reset_n=1.

Configuration
REQ-032 Macro CLA_ARB_SUB_EN: when defined, the reqn_sub ports SHALL exist and S1 SHALL register sub.
- Adder inputs become a, b^{32{sub}}, ci^sub, so a-b is computed with ci=0.
- With sub=1, rsp_co=1 means no borrow.
REQ-033 When CLA_ARB_SUB_EN is undefined, the reqn_sub ports and the sub logic SHALL be absent, and the operation is add only.

Verification
REQ-034 Single op: req0 a=5, b=7, ci=1, rsp_ready=1 -> rsp_valid 2 edges later with rsp_s=13, rsp_co=0, rsp_id=0.
REQ-035 Contention: both valid every cycle after reset -> grants alternate 0,1,0,1, with rsp_id following the same order.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles with both valid -> S1 and S2 full, both ready=0, no loss; release yields results in order.
REQ-037 Wrap: 0xFFFFFFFF+1+0 -> rsp_s=0x00000000, rsp_co=1; 0x7FFFFFFF+0x7FFFFFFF+1 -> rsp_s=0xFFFFFFFF, rsp_co=0.
REQ-038 Reset mid-flight: reset_n=0 with v1=1 and rsp_valid=1 -> rsp_valid=0 immediately; after release, req0 wins the first contention.
REQ-039 With CLA_ARB_SUB_EN: sub=1, a=3, b=5, ci=0 -> rsp_s=0xFFFFFFFE, rsp_co=0.

Source files
------------

// File: rtl/cla_arb_if.sv
// Requester/response bundle for cla_arb. Sub-select signals exist only with CLA_ARB_SUB_EN.
interface cla_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ci;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ci;
`ifdef CLA_ARB_SUB_EN
  logic        req0_sub;
  logic        req1_sub;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_s;
  logic        rsp_co;

  modport slave (
`ifdef CLA_ARB_SUB_EN
    input  req0_sub, req1_sub,
`endif
    input  req0_valid, req0_a, req0_b, req0_ci,
    input  req1_valid, req1_a, req1_b, req1_ci,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_s, rsp_co
  );

  modport master (
`ifdef CLA_ARB_SUB_EN
    output req0_sub, req1_sub,
`endif
    output req0_valid, req0_a, req0_b, req0_ci,
    output req1_valid, req1_a, req1_b, req1_ci,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_s, rsp_co
  );
endinterface

// File: rtl/cla_arb.sv
// Two-requester round-robin front end sharing one 32-bit carry-lookahead adder (2-stage pipe).
// Optional subtract support is enabled by defining CLA_ARB_SUB_EN.
module cla_arb (
  input logic      clk,
  input logic      reset_n,
  cla_arb_if.slave bus
);

  logic        v1_q, v1_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        ci_q, ci_d, id_q, id_d;
`ifdef CLA_ARB_SUB_EN
  logic        sub_q, sub_d;
`endif
  logic        last_grant_q, last_grant_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_s_q, rsp_s_d;
  logic        rsp_co_q, rsp_co_d;

  logic        adv1, adv2, grant, xfer;
  logic [31:0] op_b, sum;
  logic        op_ci, cout;

  always_comb begin
    adv2 = !rsp_valid_q || bus.rsp_ready;
    adv1 = !v1_q || adv2;
    // Under contention the requester that did not win last time is served.
    if (bus.req0_valid && bus.req1_valid) grant = !last_grant_q;
    else                                  grant = bus.req1_valid;
  end

  assign bus.req0_ready = adv1 && !grant && bus.req0_valid;
  assign bus.req1_ready = adv1 && grant && bus.req1_valid;
  assign xfer           = bus.req0_ready || bus.req1_ready;

  always_comb begin
    v1_d         = v1_q;
    a_d          = a_q;
    b_d          = b_q;
    ci_d         = ci_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
`ifdef CLA_ARB_SUB_EN
    sub_d        = sub_q;
`endif
    if (adv1) begin
      v1_d = xfer;
      if (xfer) begin
        id_d         = grant;
        last_grant_d = grant;
        a_d          = grant ? bus.req1_a  : bus.req0_a;
        b_d          = grant ? bus.req1_b  : bus.req0_b;
        ci_d         = grant ? bus.req1_ci : bus.req0_ci;
`ifdef CLA_ARB_SUB_EN
        sub_d        = grant ? bus.req1_sub : bus.req0_sub;
`endif
      end
    end
  end

  always_comb begin
`ifdef CLA_ARB_SUB_EN
    op_b  = b_q ^ {32{sub_q}};
    op_ci = ci_q ^ sub_q;
`else
    op_b  = b_q;
    op_ci = ci_q;
`endif
  end

  // 4-bit lookahead groups, group carries rippled through group generate/propagate.
  always_comb begin : cla32
    logic [31:0] g, p, c;
    logic [7:0]  gg, gp;
    logic [8:0]  cg;
    g     = a_q & op_b;
    p     = a_q ^ op_b;
    c     = '0;
    gg    = '0;
    gp    = '0;
    cg    = '0;
    cg[0] = op_ci;
    for (int k = 0; k < 8; k++) begin
      gg[k]      = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+2 +: 2] & g[4*k+1])
                 | (&p[4*k+1 +: 3] & g[4*k]);
      gp[k]      = &p[4*k +: 4];
      c[4*k]     = cg[k];
      c[4*k+1]   = g[4*k] | (p[4*k] & cg[k]);
      c[4*k+2]   = g[4*k+1] | (p[4*k+1] & g[4*k]) | (&p[4*k +: 2] & cg[k]);
      c[4*k+3]   = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (&p[4*k+1 +: 2] & g[4*k])
                 | (&p[4*k +: 3] & cg[k]);
      cg[k+1]    = gg[k] | (gp[k] & cg[k]);
    end
    sum  = p ^ c;
    cout = cg[8];
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_s_d     = rsp_s_q;
    rsp_co_d    = rsp_co_q;
    if (adv2) begin
      rsp_valid_d = v1_q;
      rsp_id_d    = id_q;
      rsp_s_d     = sum;
      rsp_co_d    = cout;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      ci_q         <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef CLA_ARB_SUB_EN
      sub_q        <= 1'b0;
`endif
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_s_q      <= '0;
      rsp_co_q     <= 1'b0;
    end else begin
      v1_q         <= v1_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ci_q         <= ci_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
`ifdef CLA_ARB_SUB_EN
      sub_q        <= sub_d;
`endif
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_s_q      <= rsp_s_d;
      rsp_co_q     <= rsp_co_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_s     = rsp_s_q;
  assign bus.rsp_co    = rsp_co_q;

endmodule

// File: tb/tb_cla_arb.sv
// Directed bench for cla_arb: handshake monitor feeds an expected/observed scoreboard.
module tb_cla_arb;

  typedef struct packed {
    logic        id;
    logic [31:0] s;
    logic        co;
  } rsp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cla_arb_if bus ();

  cla_arb dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int   tests = 0;
  int   fails = 0;
  rsp_t exp_q[$];
  rsp_t got_q[$];
  int   exp_idx = 0;
  int   got_idx = 0;
  bit   both_rdy = 1'b0;
  logic sub0, sub1;

`ifdef CLA_ARB_SUB_EN
  assign sub0 = bus.req0_sub;
  assign sub1 = bus.req1_sub;
`else
  assign sub0 = 1'b0;
  assign sub1 = 1'b0;
`endif

  function automatic rsp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sub);
    logic [32:0] r;
    logic [31:0] bb;
    rsp_t        o;
    bb   = b ^ {32{sub}};
    r    = {1'b0, a} + {1'b0, bb} + {32'd0, ci ^ sub};
    o.id = id;
    o.s  = r[31:0];
    o.co = r[32];
    return o;
  endfunction

  always @(negedge clk) begin
    if (bus.req0_ready && bus.req1_ready) both_rdy = 1'b1;
    if (reset_n) begin
      if (bus.req0_valid && bus.req0_ready)
        exp_q.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_ci, sub0));
      if (bus.req1_valid && bus.req1_ready)
        exp_q.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_ci, sub1));
      if (bus.rsp_valid && bus.rsp_ready)
        got_q.push_back('{id: bus.rsp_id, s: bus.rsp_s, co: bus.rsp_co});
    end
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sb();
    rsp_t e, g;
    while (exp_idx < exp_q.size() && got_idx < got_q.size()) begin
      e = exp_q[exp_idx];
      g = got_q[got_idx];
      chk("sb_id", {32'd0, g.id}, {32'd0, e.id});
      chk("sb_s", {1'b0, g.s}, {1'b0, e.s});
      chk("sb_co", {32'd0, g.co}, {32'd0, e.co});
      exp_idx++;
      got_idx++;
    end
  endtask

  // One clock; a port whose operation was accepted gets fresh random operands.
  task automatic run_cycle(output logic g0, output logic g1);
    @(negedge clk);
    g0 = bus.req0_valid && bus.req0_ready;
    g1 = bus.req1_valid && bus.req1_ready;
    step();
    if (g0) begin
      bus.req0_a  = $urandom;
      bus.req0_b  = $urandom;
      bus.req0_ci = 1'($urandom_range(0, 1));
    end
    if (g1) begin
      bus.req1_a  = $urandom;
      bus.req1_b  = $urandom;
      bus.req1_ci = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic single_op(input logic port, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, output logic [31:0] s, output logic co,
                           output logic id, output int lat);
    bit acc = 1'b0;
    int n   = 0;
    if (port) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_ci = ci; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_ci = ci; bus.req0_valid = 1'b1;
    end
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = port ? bus.req1_ready : bus.req0_ready;
      step();
      n++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("accept_timeout", {32'd0, acc}, 33'd1);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    s  = bus.rsp_s;
    co = bus.rsp_co;
    id = bus.rsp_id;
    step();
  endtask

  logic [31:0] s;
  logic        co, id, g0, g1;
  int          lat, nacc;

  initial begin
    reset_n        = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ci = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ci = 1'b0;
    bus.rsp_ready  = 1'b1;
`ifdef CLA_ARB_SUB_EN
    bus.req0_sub   = 1'b0;
    bus.req1_sub   = 1'b0;
`endif
    #2 reset_n = 1'b0;
    step();
    chk("rst_rsp_valid", {32'd0, bus.rsp_valid}, 33'd0);
    chk("rst_rsp_id", {32'd0, bus.rsp_id}, 33'd0);
    chk("rst_rsp_s", {1'b0, bus.rsp_s}, 33'd0);
    chk("rst_rsp_co", {32'd0, bus.rsp_co}, 33'd0);
    bus.req0_valid = 1'b1;
    #1;
    chk("rst_ready0", {32'd0, bus.req0_ready}, 33'd1);
    chk("rst_ready1", {32'd0, bus.req1_ready}, 33'd0);
    step();
    bus.req0_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("rst_no_record", {32'd0, bus.rsp_valid}, 33'd0);

    // Single add with two-edge latency.
    single_op(1'b0, 32'd5, 32'd7, 1'b1, s, co, id, lat);
    chk("single_lat", lat, 33'd1);
    chk("single_s", {1'b0, s}, 33'd13);
    chk("single_co", {32'd0, co}, 33'd0);
    chk("single_id", {32'd0, id}, 33'd0);

    single_op(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, s, co, id, lat);
    chk("wrap1_s", {1'b0, s}, 33'd0);
    chk("wrap1_co", {32'd0, co}, 33'd1);
    chk("wrap1_id", {32'd0, id}, 33'd1);
    single_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, s, co, id, lat);
    chk("wrap2_s", {1'b0, s}, {1'b0, 32'hFFFF_FFFF});
    chk("wrap2_co", {32'd0, co}, 33'd0);
    check_sb();

    // Fill S1 and S2 with the consumer stalled, then reset mid-flight.
    bus.rsp_ready  = 1'b0;
    bus.req0_a     = 32'd1; bus.req0_b = 32'd2; bus.req0_ci = 1'b0;
    bus.req0_valid = 1'b1;
    run_cycle(g0, g1);
    run_cycle(g0, g1);
    bus.req0_valid = 1'b0;
    chk("mid_pre_valid", {32'd0, bus.rsp_valid}, 33'd1);
    check_sb();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {32'd0, bus.rsp_valid}, 33'd0);
    step();
    step();
    reset_n = 1'b1;
    exp_idx = exp_q.size();
    got_idx = got_q.size();

    // Contention straight after reset: req0 first, then alternating.
    bus.rsp_ready  = 1'b1;
    bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req0_ci = 1'b1;
    bus.req1_a = $urandom; bus.req1_b = $urandom; bus.req1_ci = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_cycle(g0, g1);
      chk($sformatf("cont_g0_%0d", k), {32'd0, g0}, (k % 2 == 0) ? 33'd1 : 33'd0);
      chk($sformatf("cont_g1_%0d", k), {32'd0, g1}, (k % 2 == 1) ? 33'd1 : 33'd0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
    step();
    step();
    check_sb();

    // Backpressure with both requesters pending.
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    nacc = 0;
    for (int k = 0; k < 5; k++) begin
      run_cycle(g0, g1);
      nacc += int'(g0) + int'(g1);
    end
    chk("bp_accepts", nacc, 33'd2);
    chk("bp_ready0", {32'd0, bus.req0_ready}, 33'd0);
    chk("bp_ready1", {32'd0, bus.req1_ready}, 33'd0);
    chk("bp_rsp_valid", {32'd0, bus.rsp_valid}, 33'd1);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) run_cycle(g0, g1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
    step();
    step();
    check_sb();

`ifdef CLA_ARB_SUB_EN
    bus.req0_sub = 1'b1;
    single_op(1'b0, 32'd3, 32'd5, 1'b0, s, co, id, lat);
    bus.req0_sub = 1'b0;
    chk("sub_s", {1'b0, s}, {1'b0, 32'hFFFF_FFFE});
    chk("sub_co", {32'd0, co}, 33'd0);
    check_sb();
`endif

    step();
    step();
    check_sb();
    chk("sb_exp_drained", exp_q.size() - exp_idx, 33'd0);
    chk("sb_got_drained", got_q.size() - got_idx, 33'd0);
    chk("ready_exclusive", {32'd0, both_rdy}, 33'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
